paddle_move_sched: RTL and testbench
====================================

// Module: paddle_move_sched
// PURPOSE
//  Central move scheduler for both paddles. Decodes UART key bytes (uart_o qualified by dv) into
//  per-player held-direction commands, paces paddle motion with one shared step timer, and
//  owns/clamps both paddle Y positions. Feeds the paddle draw logic and the ball collision logic.
// PARAMETERS
//  SCREEN_H     480       visible lines; paddle Y range is 0..SCREEN_H-PADDLE_H (432)
//  PADDLE_H     48        paddle height in lines
//  STEP         1         lines moved per step tick
//  STEP_CYCLES  2500000   in_clk cycles between step ticks
//  HOLD_CYCLES  12500000  cycles a direction stays active after its last key byte (key-repeat gap)
//  ACCEL_AFTER  8         consecutive same-direction steps before acceleration (PADDLE_ACCEL_EN only)
//  K1_UP/K1_DN  8'h26/8'h28  player-1 keys;  K2_UP/K2_DN 8'h77/8'h73 player-2 keys;  K_STOP 8'h20
// PORTS
//  in_clk     in   1  system clock
//  reset      in   1  asynchronous, active-low reset
//  dv         in   1  UART byte valid, one-cycle pulse
//  uart_o     in   8  received UART byte, valid only when dv=1
//  y_paddle1  out  9  player-1 paddle top Y
//  y_paddle2  out  9  player-2 paddle top Y
//  dir1       out  2  player-1 state: 00 IDLE, 01 UP, 10 DN
//  dir2       out  2  player-2 state, same encoding
//  step_tick  out  1  one-cycle pulse on each step tick
//  cmd_err    out  1  one-cycle pulse: dv with an unmapped byte
// BEHAVIOUR
//  Reset (async, reset=0): y_paddle1=y_paddle2=216 ((SCREEN_H-PADDLE_H)/2), dir1=dir2=IDLE, hold timers=0,
//   step counter=0, step_tick=0, cmd_err=0. Outputs hold these until the first in_clk edge with reset=1.
//  Step timer: free-running 0..STEP_CYCLES-1; step_tick=1 for the cycle after count==STEP_CYCLES-1; wraps to 0.
//  Per-player FSM (independent copies, IDLE/UP/DN):
//   - dv & own UP key -> UP, hold timer loads HOLD_CYCLES-1; own DN key -> DN, same load. Applies from any
//     state; same key reloads (extends), opposite key reverses immediately.
//   - in UP/DN without a new own key: timer decrements; at 0 -> IDLE next cycle. Player is
//     UP/DN for exactly HOLD_CYCLES cycles after the last key byte.
//   - dv & K_STOP -> both players IDLE, timers cleared, next cycle.
//   - dv & unmapped byte -> cmd_err=1 next cycle; no state change. dv=0 -> uart_o ignored.
//  Position update, on step_tick only, uses the registered direction:
//   - UP: y = (y < STEP) ? 0 : y-STEP.  DN: y = (y+STEP > YMAX) ? YMAX : y+STEP, YMAX=SCREEN_H-PADDLE_H.
//   - IDLE: y unchanged. Compute in 10 bits; never wrap below 0 or above YMAX.
//  Simultaneous dv and step_tick: tick uses pre-byte direction; new direction takes effect on next tick.
//  Latency: key byte -> dir change 1 cycle; dir -> first move at next step_tick.
//  Reset asserted mid-move: all state returns to reset values immediately; partial step discarded.
// CONFIGURATION
//  PADDLE_ACCEL_EN defined: per-player counter of consecutive step ticks in the same non-IDLE
//   direction; once it reaches ACCEL_AFTER, step size = 2*STEP (same clamping). Counter clears on
//   IDLE, reversal, K_STOP, or reset; saturates at ACCEL_AFTER.
//  PADDLE_ACCEL_EN undefined: step size always STEP; no counters synthesised.
// TESTING (bench overrides STEP_CYCLES=4, HOLD_CYCLES=20, STEP=1, ACCEL_AFTER=8)
//  1. Release reset -> y_paddle1=y_paddle2=216, dir1=dir2=00, cmd_err=0, step_tick every 4th cycle.
//  2. One dv with 8'h26 -> dir1=01 for exactly 20 cycles, exactly 5 ticks, y_paddle1=211, then dir1=00; y2=216.
//  3. Repeat 8'h28 every 15 cycles -> y_paddle1 rises to 432, holds 432 on later ticks, never exceeds it.
//  4. 8'h26 then 8'h77 5 cycles later -> both paddles move independently; 8'h28 while dir1=01 -> dir1=10 next cycle.
//  5. dv 8'h20 mid-move -> dir1=dir2=00 next cycle, positions frozen; dv 8'h41 -> single cmd_err pulse, no state change.
//  6. Drop reset mid-move between ticks -> y=216, dir=00 without clock edge; with PADDLE_ACCEL_EN, held DN
//     from 216 gives steps of 1 for ticks 1-8, then 2 per tick (y=226 after 9 ticks).

Source files
------------

// File: rtl/paddle_move_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// paddle_move_sched
//   Central move scheduler for both paddles. UART key bytes become per-player
//   held-direction commands. One shared step timer paces motion. Both paddle
//   Y positions are owned and clamped to 0..SCREEN_H-PADDLE_H here.
//
//   Optional feature macro: PADDLE_ACCEL_EN.
//     When defined, each player counts consecutive step ticks in the same
//     direction. After ACCEL_AFTER such ticks it moves 2*STEP per tick.
//
// Ports
//   in_clk     in   1  system clock
//   reset      in   1  asynchronous, active-low reset
//   dv         in   1  UART byte valid, one-cycle pulse
//   uart_o     in   8  received UART byte (only meaningful while dv=1)
//   y_paddle1  out  9  player-1 paddle top Y
//   y_paddle2  out  9  player-2 paddle top Y
//   dir1       out  2  player-1 state: 00 IDLE, 01 UP, 10 DN
//   dir2       out  2  player-2 state, same encoding
//   step_tick  out  1  one-cycle pulse on each step tick
//   cmd_err    out  1  one-cycle pulse after dv carried an unmapped byte
// -----------------------------------------------------------------------------

// Per-player direction FSM, hold timer and clamped position register.
//   key_up_i/key_dn_i  own-key hits (already qualified by dv)
//   stop_i             K_STOP seen (already qualified by dv)
//   tick_i             registered step tick
//   dir_o / y_o        registered direction and paddle top Y
module paddle_player #(
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 48,
    parameter int STEP        = 1,
    parameter int HOLD_CYCLES = 12500000,
    parameter int ACCEL_AFTER = 8
) (
    input  logic       in_clk,
    input  logic       reset,
    input  logic       key_up_i,
    input  logic       key_dn_i,
    input  logic       stop_i,
    input  logic       tick_i,
    output logic [1:0] dir_o,
    output logic [8:0] y_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DN = 2'b10} dir_e;

    localparam int              HW      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]   HOLD_LD = HW'(HOLD_CYCLES - 1);
    localparam logic [9:0]      YMAX    = 10'(SCREEN_H - PADDLE_H);
    localparam logic [8:0]      YRST    = 9'((SCREEN_H - PADDLE_H) / 2);

    dir_e          dir_q, dir_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [8:0]    y_q, y_d;
    logic [9:0]    step_sz;
    logic [9:0]    y_ext, y_sum, y_up, y_dn;

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            dir_q  <= IDLE;
            hold_q <= '0;
            y_q    <= YRST;
        end else begin
            dir_q  <= dir_d;
            hold_q <= hold_d;
            y_q    <= y_d;
        end
    end

    // Priority: stop > own UP > own DN > hold countdown. The hold timer is
    // loaded with HOLD_CYCLES-1. The state then leaves UP/DN on the edge where
    // the timer reads 0. That gives exactly HOLD_CYCLES active cycles.
    always_comb begin
        dir_d  = dir_q;
        hold_d = hold_q;
        if (stop_i) begin
            dir_d  = IDLE;
            hold_d = '0;
        end else if (key_up_i) begin
            dir_d  = UP;
            hold_d = HOLD_LD;
        end else if (key_dn_i) begin
            dir_d  = DN;
            hold_d = HOLD_LD;
        end else if (dir_q != IDLE) begin
            if (hold_q == '0) begin
                dir_d = IDLE;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end
    end

`ifdef PADDLE_ACCEL_EN
    localparam int            AW      = $clog2(ACCEL_AFTER + 1);
    localparam logic [AW-1:0] ACC_SAT = AW'(ACCEL_AFTER);

    logic [AW-1:0] acc_q, acc_d;

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    // Any direction change clears the run. That covers IDLE, reversal and
    // stop. A same-key reload leaves dir unchanged and keeps the run going.
    always_comb begin
        acc_d = acc_q;
        if (dir_q == IDLE || dir_d != dir_q) begin
            acc_d = '0;
        end else if (tick_i && acc_q != ACC_SAT) begin
            acc_d = acc_q + AW'(1);
        end
    end

    assign step_sz = (acc_q == ACC_SAT) ? 10'(2 * STEP) : 10'(STEP);
`else
    assign step_sz = 10'(STEP);
`endif

    // Arithmetic is done 10 bits wide. Underflow and overflow are caught
    // before they can wrap the 9-bit position.
    always_comb begin
        y_ext = {1'b0, y_q};
        y_sum = y_ext + step_sz;
        y_up  = (y_ext < step_sz) ? 10'd0 : (y_ext - step_sz);
        y_dn  = (y_sum > YMAX) ? YMAX : y_sum;
        y_d   = y_q;
        if (tick_i) begin
            case (dir_q)
                UP:      y_d = y_up[8:0];
                DN:      y_d = y_dn[8:0];
                default: y_d = y_q;
            endcase
        end
    end

    assign dir_o = dir_q;
    assign y_o   = y_q;
endmodule

module paddle_move_sched #(
    parameter int         SCREEN_H    = 480,
    parameter int         PADDLE_H    = 48,
    parameter int         STEP        = 1,
    parameter int         STEP_CYCLES = 2500000,
    parameter int         HOLD_CYCLES = 12500000,
    parameter int         ACCEL_AFTER = 8,
    parameter logic [7:0] K1_UP       = 8'h26,
    parameter logic [7:0] K1_DN       = 8'h28,
    parameter logic [7:0] K2_UP       = 8'h77,
    parameter logic [7:0] K2_DN       = 8'h73,
    parameter logic [7:0] K_STOP      = 8'h20
) (
    input  logic       in_clk,
    input  logic       reset,
    input  logic       dv,
    input  logic [7:0] uart_o,
    output logic [8:0] y_paddle1,
    output logic [8:0] y_paddle2,
    output logic [1:0] dir1,
    output logic [1:0] dir2,
    output logic       step_tick,
    output logic       cmd_err
);
    localparam int NUM_PLAYERS = 2;
    localparam int SW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    localparam logic [NUM_PLAYERS-1:0][7:0] UP_KEYS = {K2_UP, K1_UP};
    localparam logic [NUM_PLAYERS-1:0][7:0] DN_KEYS = {K2_DN, K1_DN};

    typedef struct packed {
        logic up;
        logic dn;
    } key_cmd_t;

    key_cmd_t [NUM_PLAYERS-1:0]       cmd;
    logic                             key_stop;
    logic                             key_mapped;
    logic [NUM_PLAYERS-1:0][8:0]      y_all;
    logic [NUM_PLAYERS-1:0][1:0]      dir_all;

    logic [SW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          err_q, err_d;

    // Key decode shared by both players. Stop is global.
    always_comb begin
        cmd        = '0;
        key_stop   = dv && (uart_o == K_STOP);
        key_mapped = (uart_o == K_STOP);
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            cmd[p].up  = dv && (uart_o == UP_KEYS[p]);
            cmd[p].dn  = dv && (uart_o == DN_KEYS[p]);
            key_mapped = key_mapped || (uart_o == UP_KEYS[p]) || (uart_o == DN_KEYS[p]);
        end
    end

    // The tick is registered, so it pulses the cycle after the terminal count.
    always_comb begin
        cnt_d  = (cnt_q == STEP_LAST) ? '0 : cnt_q + SW'(1);
        tick_d = (cnt_q == STEP_LAST);
        err_d  = dv && !key_mapped;
    end

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        paddle_player #(
            .SCREEN_H    (SCREEN_H),
            .PADDLE_H    (PADDLE_H),
            .STEP        (STEP),
            .HOLD_CYCLES (HOLD_CYCLES),
            .ACCEL_AFTER (ACCEL_AFTER)
        ) u_player (
            .in_clk   (in_clk),
            .reset    (reset),
            .key_up_i (cmd[p].up),
            .key_dn_i (cmd[p].dn),
            .stop_i   (key_stop),
            .tick_i   (tick_q),
            .dir_o    (dir_all[p]),
            .y_o      (y_all[p])
        );
    end

    assign y_paddle1 = y_all[0];
    assign y_paddle2 = y_all[1];
    assign dir1      = dir_all[0];
    assign dir2      = dir_all[1];
    assign step_tick = tick_q;
    assign cmd_err   = err_q;
endmodule

// File: tb/tb_paddle_move_sched.sv
`timescale 1ns/1ps
module tb_paddle_move_sched;
    localparam int S_Y1 = 0, S_Y2 = 1, S_D1 = 2, S_D2 = 3, S_TICK = 4, S_ERR = 5;

`ifdef PADDLE_ACCEL_EN
    localparam int CL_A = 497;   // y1 reaches 431 earlier with 2-line steps
    localparam int CL_B = 501;
    localparam int ACC9 = 226;
`else
    localparam int CL_A = 921;
    localparam int CL_B = 925;
    localparam int ACC9 = 225;
`endif

    logic       in_clk = 1'b0;
    logic       reset;
    logic       dv;
    logic [7:0] uart_o;
    logic [8:0] y_paddle1, y_paddle2;
    logic [1:0] dir1, dir2;
    logic       step_tick, cmd_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string nm;
    } exp_t;
    exp_t sbq[$];

    paddle_move_sched #(
        .SCREEN_H(480), .PADDLE_H(48), .STEP(1),
        .STEP_CYCLES(4), .HOLD_CYCLES(20), .ACCEL_AFTER(8)
    ) dut (
        .in_clk(in_clk), .reset(reset), .dv(dv), .uart_o(uart_o),
        .y_paddle1(y_paddle1), .y_paddle2(y_paddle2),
        .dir1(dir1), .dir2(dir2), .step_tick(step_tick), .cmd_err(cmd_err)
    );

    always #5 in_clk = ~in_clk;

    // Cycle index counts active edges since reset release. It freezes while
    // reset is low.
    always @(posedge in_clk) if (reset) cyc <= cyc + 1;

    function automatic int sample(int sig);
        case (sig)
            S_Y1:    return int'(y_paddle1);
            S_Y2:    return int'(y_paddle2);
            S_D1:    return int'(dir1);
            S_D2:    return int'(dir2);
            S_TICK:  return int'(step_tick);
            default: return int'(cmd_err);
        endcase
    endfunction

    task automatic chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic ex(int c, int sig, int val, string nm);
        exp_t e;
        e.cyc = c; e.sig = sig; e.val = val; e.nm = nm;
        sbq.push_back(e);
    endtask

    // Monitor: pops every expectation due this cycle and checks the position bound.
    always @(negedge in_clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            if (e.cyc < cyc) begin
                checks++; errors++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
            end else begin
                chk(e.nm, sample(e.sig), e.val);
            end
        end
        chk("y1_le_ymax", (y_paddle1 <= 9'd432) ? 1 : 0, 1);
        chk("y2_le_ymax", (y_paddle2 <= 9'd432) ? 1 : 0, 1);
    end

    task automatic wait_cyc(int n);
        while (cyc < n) @(negedge in_clk);
    endtask

    task automatic send(logic [7:0] b);
        dv = 1'b1; uart_o = b;
        @(negedge in_clk);
        dv = 1'b0; uart_o = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; dv = 1'b0; uart_o = 8'h00;

        // reset state and tick cadence
        ex(0, S_Y1, 216, "rst_y1");  ex(0, S_Y2, 216, "rst_y2");
        ex(0, S_D1, 0, "rst_d1");    ex(0, S_D2, 0, "rst_d2");
        ex(0, S_ERR, 0, "rst_err");  ex(0, S_TICK, 0, "rst_tick");
        ex(3, S_TICK, 0, "tick3");   ex(4, S_TICK, 1, "tick4");
        ex(5, S_TICK, 0, "tick5");   ex(8, S_TICK, 1, "tick8");
        // single UP key: 20 cycles, 5 ticks
        ex(10, S_D1, 0, "up_pre");   ex(11, S_D1, 1, "up_lat");
        ex(12, S_TICK, 1, "tick12"); ex(13, S_Y1, 215, "up_first");
        ex(29, S_Y1, 211, "up_five");ex(30, S_D1, 1, "up_last");
        ex(31, S_D1, 0, "up_expire");ex(33, S_Y1, 211, "up_frozen");
        ex(33, S_Y2, 216, "y2_still");
        // repeated DN to the bottom clamp
        ex(45, S_Y1, 212, "dn_first");
        ex(CL_A, S_Y1, 431, "dn_431"); ex(CL_B, S_Y1, 432, "dn_432");
        ex(1005, S_Y1, 432, "dn_hold");ex(1020, S_D1, 2, "dn_last");
        ex(1021, S_D1, 0, "dn_expire");ex(1021, S_Y1, 432, "dn_clamp");
        // independent players and reversal
        ex(1031, S_D1, 1, "p1_up");    ex(1033, S_Y1, 431, "p1_mv1");
        ex(1036, S_D2, 1, "p2_up");    ex(1037, S_Y1, 430, "p1_mv2");
        ex(1037, S_Y2, 215, "p2_mv1"); ex(1038, S_D1, 1, "p1_pre_rev");
        ex(1039, S_D1, 2, "p1_rev");   ex(1041, S_Y1, 431, "p1_rev_mv");
        ex(1041, S_Y2, 214, "p2_mv2");
        // stop, bad byte, ignored byte
        ex(1042, S_D1, 2, "pre_stop"); ex(1043, S_D1, 0, "stop_d1");
        ex(1043, S_D2, 0, "stop_d2");  ex(1043, S_ERR, 0, "stop_noerr");
        ex(1045, S_Y1, 431, "stop_y1");ex(1045, S_Y2, 214, "stop_y2");
        ex(1050, S_ERR, 0, "err_pre"); ex(1051, S_ERR, 1, "err_pulse");
        ex(1051, S_D1, 0, "err_nochg");ex(1052, S_ERR, 0, "err_single");
        ex(1053, S_Y1, 431, "err_y1"); ex(1056, S_D1, 0, "nodv_d1");
        ex(1056, S_ERR, 0, "nodv_err");ex(1061, S_D1, 2, "pre_rst_dn");
        ex(1065, S_Y1, 432, "pre_rst_clamp");
        // after mid-move reset: tick phase restarts, held DN run
        ex(1069, S_TICK, 0, "rr_tick0");ex(1069, S_D1, 2, "rr_dn");
        ex(1070, S_TICK, 1, "rr_tick1");ex(1071, S_Y1, 217, "rr_mv1");
        ex(1099, S_Y1, 224, "rr_mv8"); ex(1103, S_Y1, ACC9, "rr_mv9");
        ex(1103, S_Y2, 216, "rr_y2");  ex(1116, S_D1, 0, "rr_expire");

        repeat (3) @(negedge in_clk);
        reset = 1'b1;

        wait_cyc(10); send(8'h26);
        for (int m = 0; m <= 64; m++) begin
            wait_cyc(40 + 15 * m); send(8'h28);
        end
        wait_cyc(1030); send(8'h26);
        wait_cyc(1035); send(8'h77);
        wait_cyc(1038); send(8'h28);
        wait_cyc(1042); send(8'h20);
        wait_cyc(1050); send(8'h41);
        wait_cyc(1055); uart_o = 8'h26;   // dv low: must be ignored
        @(negedge in_clk); uart_o = 8'h00;
        wait_cyc(1060); send(8'h28);

        // reset in the middle of a move, between ticks: must act with no clock edge
        wait_cyc(1066);
        #2 reset = 1'b0;
        #1;
        chk("async_y1", int'(y_paddle1), 216);
        chk("async_y2", int'(y_paddle2), 216);
        chk("async_d1", int'(dir1), 0);
        chk("async_tick", int'(step_tick), 0);
        repeat (3) @(negedge in_clk);
        reset = 1'b1;

        wait_cyc(1068); send(8'h28);
        wait_cyc(1080); send(8'h28);
        wait_cyc(1095); send(8'h28);
        wait_cyc(1130);

        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++; errors++;
            $display("FAIL %s: got no observation expected check at cycle %0d", e.nm, e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
